// File: rtl/fifo_read_packer.sv
// Packs RATIO consecutive FWFT FIFO entries into one wide word with a per-lane keep mask.
// Latency: word valid one cycle after its final read (or after the flush cycle).
// Backpressure: out_valid holds until out_ready; no reads while a word waits unaccepted.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   enable                - gates new FIFO reads; a pending output word still completes
//   fifo_empty, fifo_data - FIFO first-word-fall-through head
//   fifo_read_en          - combinational pop strobe to the FIFO
//   flush                 - emit the partially filled word (sampled only while filling)
//   out_data, out_keep    - packed word, lane k at [k*DATA_WIDTH +: DATA_WIDTH], lane mask
//   out_valid, out_ready  - valid/ready handshake toward downstream
module fifo_read_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        fifo_read_en,
  input  logic                        flush,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]            out_keep,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int OUT_WIDTH = DATA_WIDTH * RATIO;
  localparam int CW        = $clog2(RATIO + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [OUT_WIDTH-1:0] pack_q;
  logic [OUT_WIDTH-1:0] pack_nxt;
  logic [CW-1:0]        n_cnt;
  logic [RATIO-1:0]     keep_nxt;

  // A read in OUT only happens in the acceptance cycle, so the slot frees up
  // in the same cycle and the stream continues without a bubble.
  assign fifo_read_en = !reset && enable && !fifo_empty &&
                        (state == FILL || (state == OUT && out_ready));

  assign n_cnt = count + {{(CW-1){1'b0}}, fifo_read_en};

  // count and pack_q are both zero while in OUT, so the same lane-insert logic
  // drops an acceptance-cycle read into lane 0.
  always_comb begin
    pack_nxt = pack_q;
    keep_nxt = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (fifo_read_en && count == CW'(i))
        pack_nxt[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      keep_nxt[i] = (CW'(i) < n_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      count     <= '0;
      pack_q    <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          // A flush with nothing collected is dropped: empty words are never emitted.
          if (n_cnt == FULL_CNT || (flush && n_cnt != '0)) begin
            out_data  <= pack_nxt;
            out_keep  <= keep_nxt;
            out_valid <= 1'b1;
            state     <= OUT;
            count     <= '0;
            pack_q    <= '0;
          end else begin
            count  <= n_cnt;
            pack_q <= pack_nxt;
          end
        end
        OUT: begin
          // RATIO >= 2, so a single acceptance-cycle read never completes a word.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= FILL;
            count     <= n_cnt;
            pack_q    <= pack_nxt;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_packer.sv
module tb_fifo_read_packer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_read_en;
  logic        flush;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;

  int nvec = 0;
  int nbad = 0;

  fifo_read_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .flush        (flush),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock cycle: inputs held for the cycle, expected outputs
  // observed during that cycle (before the closing rising edge).
  typedef struct {
    logic        rst, en, emp;
    logic [7:0]  dat;
    logic        fl, rdy;
    logic        e_rd, e_vld;
    logic [31:0] e_dat;
    logic [3:0]  e_keep;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic en, logic emp, logic [7:0] dat,
                              logic fl, logic rdy, logic e_rd, logic e_vld,
                              logic [31:0] e_dat, logic [3:0] e_keep);
    vec_t v;
    v.rst = rst; v.en = en; v.emp = emp; v.dat = dat; v.fl = fl; v.rdy = rdy;
    v.e_rd = e_rd; v.e_vld = e_vld; v.e_dat = e_dat; v.e_keep = e_keep;
    return v;
  endfunction

  // Data and keep are only meaningful while out_valid is expected high.
  task automatic check_cycle(input string name, input logic e_rd, input logic e_vld,
                             input logic [31:0] e_dat, input logic [3:0] e_keep);
    logic bad;
    bad = (fifo_read_en !== e_rd) || (out_valid !== e_vld) ||
          (e_vld && ((out_data !== e_dat) || (out_keep !== e_keep)));
    nvec++;
    if (bad) begin
      nbad++;
      $display("FAIL %s: got rd=%b vld=%b data=%h keep=%h, want rd=%b vld=%b data=%h keep=%h",
               name, fifo_read_en, out_valid, out_data, out_keep, e_rd, e_vld, e_dat, e_keep);
    end
  endtask

  initial begin
    //         rst en emp dat    fl rdy  rd vld data          keep
    // reset holds off reads even with data present
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0));
    // basic pack
    tbl.push_back(mk(0, 1, 0, 8'h11, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h22, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h33, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h44, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 1, 32'h44332211, 4'hF));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0));
    // backpressure, then acceptance-cycle read with no bubble
    tbl.push_back(mk(0, 1, 0, 8'h01, 0, 0, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h02, 0, 0, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h03, 0, 0, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h04, 0, 0, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h05, 0, 0, 0, 1, 32'h04030201, 4'hF));
    tbl.push_back(mk(0, 1, 0, 8'h05, 0, 0, 0, 1, 32'h04030201, 4'hF));
    tbl.push_back(mk(0, 1, 0, 8'h05, 0, 1, 1, 1, 32'h04030201, 4'hF));
    tbl.push_back(mk(0, 1, 0, 8'h06, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h07, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h08, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 1, 32'h08070605, 4'hF));
    // partial flush after two entries
    tbl.push_back(mk(0, 1, 0, 8'hAA, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'hBB, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 1, 1, 0, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 1, 32'h0000BBAA, 4'h3));
    // flush coinciding with the third read
    tbl.push_back(mk(0, 1, 0, 8'hAA, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'hBB, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'hCC, 1, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 1, 32'h00CCBBAA, 4'h7));
    // null flush on an empty FIFO
    tbl.push_back(mk(0, 1, 1, 8'h00, 1, 1, 0, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0));
    // enable low holds a partial word; flush still emits it; OUT completes with enable low
    tbl.push_back(mk(0, 1, 0, 8'h5A, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 0, 0, 8'h5B, 0, 1, 0, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 0, 0, 8'h5B, 1, 1, 0, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 32'h0000005A, 4'h1));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0));
    // flush while a full word waits in OUT is ignored
    tbl.push_back(mk(0, 1, 0, 8'h61, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h62, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h63, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h64, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 1, 0, 0, 1, 32'h64636261, 4'hF));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 1, 32'h64636261, 4'hF));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0));
    // reset mid-word discards the three collected lanes
    tbl.push_back(mk(0, 1, 0, 8'h71, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h72, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h73, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(1, 1, 0, 8'h74, 0, 1, 0, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'hD1, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'hD2, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'hD3, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'hD4, 0, 1, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 1, 32'hD4D3D2D1, 4'hF));
    // reset discards a pending unaccepted word
    tbl.push_back(mk(0, 1, 0, 8'h81, 0, 0, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h82, 0, 0, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h83, 0, 0, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 0, 8'h84, 0, 0, 1, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 0, 0, 1, 32'h84838281, 4'hF));
    tbl.push_back(mk(1, 1, 1, 8'h00, 0, 0, 0, 1, 32'h84838281, 4'hF));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 0, 0, 0, 32'h0,        4'h0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0));

    reset = 1'b1; enable = 1'b1; fifo_empty = 1'b1; fifo_data = 8'h00;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, with data offered so the read gate is exercised.
    @(negedge clk);
    fifo_empty = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0 || fifo_read_en !== 1'b0) begin
      nbad++;
      $display("FAIL reset_state: got vld=%b data=%h keep=%h rd=%b, want all zero",
               out_valid, out_data, out_keep, fifo_read_en);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; enable = tbl[i].en; fifo_empty = tbl[i].emp;
      fifo_data = tbl[i].dat; flush = tbl[i].fl; out_ready = tbl[i].rdy;
      #1;
      check_cycle($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_vld, tbl[i].e_dat, tbl[i].e_keep);
    end

    // Streaming: 12 back-to-back entries, one word every 4 cycles.
    for (int c = 0; c < 15; c++) begin
      logic        e_vld;
      logic [31:0] e_dat;
      @(negedge clk);
      reset = 1'b0; enable = 1'b1; flush = 1'b0; out_ready = 1'b1;
      fifo_empty = (c >= 12);
      fifo_data  = 8'hC0 + 8'(c);
      #1;
      e_vld = (c == 4 || c == 8 || c == 12);
      e_dat = '0;
      if (e_vld) begin
        for (int k = 0; k < 4; k++)
          e_dat[k*8 +: 8] = 8'hC0 + 8'(c - 4 + k);
      end
      check_cycle($sformatf("stream%0d", c), (c < 12), e_vld, e_dat, 4'hF);
    end

    // Reset state again after a post-reset idle cycle: data register cleared.
    @(negedge clk);
    reset = 1'b1; fifo_empty = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0) begin
      nbad++;
      $display("FAIL reset_clear: got vld=%b data=%h keep=%h, want all zero",
               out_valid, out_data, out_keep);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/fifo_read_packer.md
Name: fifo_read_packer

Overview:
- Read-side consumer for the team's synchronous FIFO.
- Drains DATA_WIDTH-bit entries from the FIFO's first-word-fall-through read port and packs RATIO consecutive entries into one wide word.
- Presents each packed word on a valid/ready stream toward the downstream bus logic.
- A flush input forces out a partially filled word, with a per-lane keep mask.

Parameters:
- DATA_WIDTH, 8: width of one FIFO entry (one lane).
- RATIO, 4: entries packed per output word. Legal range 2..16.
- OUT_WIDTH, DATA_WIDTH*RATIO: derived, not overridable. Width of out_data.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new FIFO reads start. A word already in OUT still completes.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO head entry; valid whenever fifo_empty=0.
- fifo_read_en  out  1  pop strobe to the FIFO; one entry is consumed per cycle high.
- flush  in  1  single-cycle request to emit the partial word.
- out_data  out  OUT_WIDTH  packed word. Lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_keep  out  RATIO  lane-valid mask for out_data.
- out_valid  out  1  out_data/out_keep are valid.
- out_ready  in  1  downstream accepts the word when out_valid=1 and out_ready=1.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; clk and reset are the port names.
- Reset values: state=FILL, count=0, pack register=0, out_data=0, out_keep=0, out_valid=0.
- fifo_read_en is combinational and is 0 whenever reset=1.
- Read rule:
  - fifo_read_en = !reset && enable && !fifo_empty && (state==FILL || (state==OUT && out_ready)).
  - fifo_read_en is never asserted while fifo_empty=1.
- Lane order: the first entry read goes to lane 0 (LSBs). Lanes not yet filled hold 0.
- FILL state:
  - On a read, fifo_data is written to lane[count]. Let n = count + read.
  - If n==RATIO: go to OUT with out_keep all ones. count is cleared.
  - Else if flush && n>0: go to OUT with out_keep[i]=1 for i<n, 0 otherwise. count is cleared.
  - Else if flush && n==0: flush is ignored, and no empty word is ever emitted.
  - Otherwise: count=n and the block stays in FILL.
- OUT state:
  - out_valid=1. out_data and out_keep stay stable until accepted.
  - No reads occur while out_ready=0.
  - On out_ready=1: the word is accepted and out_valid drops next cycle unless a new word completes.
  - If a read occurs in the same acceptance cycle, that entry loads into lane 0, count=1, state=FILL. This sustains one entry per cycle with no bubble.
  - flush is ignored in OUT (it is sampled only in FILL).
- Latency: the word is visible with out_valid one cycle after the cycle of its final read, or after the flush cycle.
- Throughput: with the FIFO non-empty and out_ready=1, fifo_read_en stays high every cycle and one word is emitted every RATIO cycles.
- enable low in FILL: the partial contents are held. flush still emits them (n=count).
- Reset mid-operation: partial lanes and a pending output word are discarded. Entries already popped are lost; this is accepted.
- count width: clog2(RATIO+1). It must never exceed RATIO.

Test Plan:
- Basic pack: after reset, FIFO holds 0x11,0x22,0x33,0x44, enable=1, out_ready=1 -> fifo_read_en high 4 cycles; next cycle out_valid=1, out_data=0x44332211, out_keep=0xF for exactly one cycle.
- Backpressure: 8 entries 0x01..0x08 queued, out_ready=0 -> first word 0x04030201 held stable; fifo_read_en=0 while waiting. On out_ready=1, the read of 0x05 occurs in the acceptance cycle, then word 0x08070605 follows with no bubble.
- Streaming: 12 entries, out_ready=1 -> fifo_read_en high 12 consecutive cycles; 3 words emitted at a 4-cycle spacing.
- Partial flush: entries 0xAA,0xBB, then flush pulse -> out_data=0x0000BBAA, out_keep=0x3. flush in the same cycle as the read of 0xCC after 0xAA,0xBB -> 0x00CCBBAA, keep 0x7.
- Null flush / empty guard: fifo_empty=1, count=0, flush pulse -> out_valid stays 0. fifo_read_en stays 0 throughout all empty cycles.
- Reset mid-word: after 3 entries, assert reset 1 cycle -> out_valid=0, count=0. The next 4 entries 0xD1..0xD4 form exactly 0xD4D3D2D1, keep 0xF.
